input_conditioner_bank: RTL and testbench
=========================================

// Module: input_conditioner_bank
// PURPOSE
//  Parametrised N-channel push-button conditioner; replaces the per-button debouncer bank in the board top.
//  Per channel: 2-FF+ synchroniser, polarity normalisation, debounce, then event pulses (press, release, long-press).
//  Feeds logic_controller/clap_controller with clean levels and single-cycle events; runs entirely on CLK100MHZ.
// PARAMETERS
//  N_CH             6            number of button channels
//  SYNC_STAGES      2            synchroniser depth (>=2)
//  DEBOUNCE_CYCLES  1_000_000    stable cycles required to accept a change (10 ms @100 MHz; >=2)
//  LONG_CYCLES      100_000_000  held cycles before long_o fires (1 s; > DEBOUNCE_CYCLES)
//  REPEAT_CYCLES    20_000_000   auto-repeat period after long press (only with macro)
//  ACT_LOW_MASK     6'b000001    bit=1: raw input active-low (e.g. CPU_RESETN), inverted before debounce
// PORTS
//  clk_i      in   1     system clock
//  rst_i      in   1     synchronous reset, active-high
//  btn_i      in   N_CH  raw asynchronous button pins
//  level_o    out  N_CH  debounced level, 1 = pressed (active-high after normalisation)
//  press_o    out  N_CH  1-cycle pulse on accepted 0->1
//  release_o  out  N_CH  1-cycle pulse on accepted 1->0
//  long_o     out  N_CH  1-cycle pulse once per press after LONG_CYCLES held
//  repeat_o   out  N_CH  1-cycle auto-repeat pulses (tied 0 without macro)
// BEHAVIOUR
//  - One clock, synchronous active-high reset. Reset: all outputs 0; sync regs load the inactive raw value
//    (ACT_LOW_MASK bit) so no spurious press follows reset; all counters 0; FSM IDLE.
//  - Sync: SYNC_STAGES flops per channel, then s = sync ^ ACT_LOW_MASK[ch].
//  - Debounce counter db_cnt, width $clog2(DEBOUNCE_CYCLES): if s==level -> clear; else increment;
//    at db_cnt==DEBOUNCE_CYCLES-1 and s!=level: level<=s, db_cnt<=0. Any bounce before that clears the count.
//  - Latency raw edge -> level_o: SYNC_STAGES + DEBOUNCE_CYCLES cycles; press_o/release_o asserted in the
//    same cycle level_o changes (all outputs registered).
//  - Per-channel FSM: IDLE -> HELD on press; HELD -> LONG when hold_cnt==LONG_CYCLES-1 (long_o pulse);
//    HELD/LONG -> IDLE on release. hold_cnt clears on press and saturates in LONG (never wraps).
//  - Long press: exactly one long_o per press; release before threshold -> no long_o.
//  - Release in the same cycle hold_cnt hits threshold: release wins, no long_o, state IDLE.
//  - rst_i mid-press: immediate return to reset state; a still-held button re-reports press after
//    SYNC_STAGES+DEBOUNCE_CYCLES cycles.
//  - Channels fully independent; simultaneous events on several channels all reported same cycle.
// CONFIGURATION
//  - Macro ICB_AUTOREPEAT_EN defined: in LONG, rep_cnt counts; repeat_o pulses every REPEAT_CYCLES cycles,
//    first pulse REPEAT_CYCLES after long_o; rep_cnt clears on release/reset.
//  - Undefined: repeat_o tied to 0, rep_cnt and REPEAT_CYCLES logic not elaborated.
// STRUCTURE
//  - Package icb_pkg: typedef enum logic [1:0] {ICB_IDLE, ICB_HELD, ICB_LONG} icb_state_t;
//    default timing constants for 100 MHz (ICB_DEBOUNCE_10MS, ICB_LONG_1S, ICB_REPEAT_200MS).
//  - Sub-module icb_channel (one button: sync, debounce, FSM, counters), generated N_CH times;
//    top only slices buses and applies ACT_LOW_MASK.
// TESTING  (sim params: N_CH=3, DEBOUNCE_CYCLES=8, LONG_CYCLES=32, REPEAT_CYCLES=8, ACT_LOW_MASK=3'b100)
//  1 Reset with btn_i=3'b100 held -> all outputs 0 for 20 cycles after reset release (no false press).
//  2 ch0 clean 0->1 held 20 cycles -> level_o[0] rises exactly 2+8 cycles later with one press_o pulse.
//  3 ch0 bounce: 1 for 5, 0 for 2, then 1 steady -> no press until 8 stable cycles after last bounce.
//  4 ch1 held 60 cycles -> one long_o 32 cycles after press_o; release -> one release_o; no further long_o.
//  5 ch2 (active-low) driven 0 -> press_o[2]; ch0/ch1 pressed same cycle -> press_o=3'b111 same cycle.
//  6 ICB_AUTOREPEAT_EN: ch0 held 60 cycles -> repeat_o[0] pulses at long_o+8, +16, +24; stops on release.

Source files
------------

// File: rtl/icb_pkg.sv
// ============================================================================
//  Module   : icb_pkg
//  Brief    : Shared types and 100 MHz default timing for input_conditioner_bank.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package icb_pkg;

    typedef enum logic [1:0] {
        ICB_IDLE = 2'd0,
        ICB_HELD = 2'd1,
        ICB_LONG = 2'd2
    } icb_state_t;

    localparam int unsigned ICB_DEBOUNCE_10MS = 1_000_000;
    localparam int unsigned ICB_LONG_1S       = 100_000_000;
    localparam int unsigned ICB_REPEAT_200MS  = 20_000_000;

endpackage

`default_nettype wire

// File: rtl/icb_channel.sv
// ============================================================================
//  Module   : icb_channel
//  Brief    : One button: synchroniser, polarity fix, debounce, press/release/
//             long-press events; auto-repeat when ICB_AUTOREPEAT_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module icb_channel
    import icb_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = ICB_DEBOUNCE_10MS,
    parameter int unsigned LONG_CYCLES     = ICB_LONG_1S,
`ifdef ICB_AUTOREPEAT_EN
    parameter int unsigned REPEAT_CYCLES   = ICB_REPEAT_200MS,
`endif
    parameter logic        ACT_LOW         = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_o,
    output logic repeat_o
);

    localparam int unsigned c_DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned c_HOLD_W = $clog2(LONG_CYCLES);
    localparam logic [c_DB_W-1:0]   c_DB_LAST   = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(LONG_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [c_DB_W-1:0]      r_db_cnt;
    logic [c_HOLD_W-1:0]    r_hold_cnt;
    logic                   r_level;
    logic                   r_press;
    logic                   r_release;
    logic                   r_long;
    icb_state_t             r_state;
    icb_state_t             w_state_nxt;
    logic                   w_s;
    logic                   w_diff;
    logic                   w_accept;
    logic                   w_rise;
    logic                   w_fall;
    logic                   w_long;

    // Reset loads the idle raw level so no edge is seen when reset releases
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync <= {SYNC_STAGES{ACT_LOW}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], btn_i};
        end
    end

    assign w_s      = r_sync[SYNC_STAGES-1] ^ ACT_LOW;
    assign w_diff   = (w_s != r_level);
    assign w_accept = w_diff && (r_db_cnt == c_DB_LAST);
    assign w_rise   = w_accept && w_s;
    assign w_fall   = w_accept && !w_s;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_db_cnt  <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_press   <= w_rise;
            r_release <= w_fall;
            if (!w_diff) begin
                r_db_cnt <= '0;
            end else if (w_accept) begin
                r_db_cnt <= '0;
                r_level  <= w_s;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    // Release is tested first so it beats a threshold hit in the same cycle
    always_comb begin
        w_state_nxt = r_state;
        w_long      = 1'b0;
        case (r_state)
            ICB_IDLE: begin
                if (w_rise) begin
                    w_state_nxt = ICB_HELD;
                end
            end
            ICB_HELD: begin
                if (w_fall) begin
                    w_state_nxt = ICB_IDLE;
                end else if (r_hold_cnt == c_HOLD_LAST) begin
                    w_state_nxt = ICB_LONG;
                    w_long      = 1'b1;
                end
            end
            ICB_LONG: begin
                if (w_fall) begin
                    w_state_nxt = ICB_IDLE;
                end
            end
            default: begin
                w_state_nxt = ICB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ICB_IDLE;
            r_hold_cnt <= '0;
            r_long     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_long  <= w_long;
            if (w_rise) begin
                r_hold_cnt <= '0;
            end else if (r_state == ICB_HELD && w_state_nxt == ICB_HELD) begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end
        end
    end

`ifdef ICB_AUTOREPEAT_EN
    localparam int unsigned c_REP_W = $clog2(REPEAT_CYCLES + 1);
    localparam logic [c_REP_W-1:0] c_REP_LAST = c_REP_W'(REPEAT_CYCLES - 1);

    logic [c_REP_W-1:0] r_rep_cnt;
    logic               r_repeat;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rep_cnt <= '0;
            r_repeat  <= 1'b0;
        end else begin
            r_repeat <= 1'b0;
            if (r_state == ICB_LONG && w_state_nxt == ICB_LONG) begin
                if (r_rep_cnt == c_REP_LAST) begin
                    r_rep_cnt <= '0;
                    r_repeat  <= 1'b1;
                end else begin
                    r_rep_cnt <= r_rep_cnt + 1'b1;
                end
            end else begin
                r_rep_cnt <= '0;
            end
        end
    end

    assign repeat_o = r_repeat;
`else
    assign repeat_o = 1'b0;
`endif

    assign level_o   = r_level;
    assign press_o   = r_press;
    assign release_o = r_release;
    assign long_o    = r_long;

endmodule

`default_nettype wire

// File: rtl/input_conditioner_bank.sv
// ============================================================================
//  Module   : input_conditioner_bank
//  Brief    : N-channel push-button conditioner (clean levels + event pulses).
//             Define ICB_AUTOREPEAT_EN to enable repeat_o auto-repeat pulses.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module input_conditioner_bank
    import icb_pkg::*;
#(
    parameter int unsigned      N_CH            = 6,
    parameter int unsigned      SYNC_STAGES     = 2,
    parameter int unsigned      DEBOUNCE_CYCLES = ICB_DEBOUNCE_10MS,
    parameter int unsigned      LONG_CYCLES     = ICB_LONG_1S,
    parameter int unsigned      REPEAT_CYCLES   = ICB_REPEAT_200MS,
    parameter logic [N_CH-1:0]  ACT_LOW_MASK    = N_CH'(1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [N_CH-1:0] btn_i,
    output logic [N_CH-1:0] level_o,
    output logic [N_CH-1:0] press_o,
    output logic [N_CH-1:0] release_o,
    output logic [N_CH-1:0] long_o,
    output logic [N_CH-1:0] repeat_o
);

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        icb_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES),
`ifdef ICB_AUTOREPEAT_EN
            .REPEAT_CYCLES   (REPEAT_CYCLES),
`endif
            .ACT_LOW         (ACT_LOW_MASK[gi])
        ) u_channel (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .btn_i     (btn_i[gi]),
            .level_o   (level_o[gi]),
            .press_o   (press_o[gi]),
            .release_o (release_o[gi]),
            .long_o    (long_o[gi]),
            .repeat_o  (repeat_o[gi])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_input_conditioner_bank.sv
// ============================================================================
//  Module   : tb_input_conditioner_bank
//  Brief    : Scoreboard bench for input_conditioner_bank (3 channels, short timing).
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_input_conditioner_bank;

    localparam int c_DB  = 8;
    localparam int c_LG  = 32;
    localparam int c_RP  = 8;
    localparam int c_LAT = 2 + c_DB;

    typedef struct {
        int         cyc;
        logic [2:0] lvl;
        logic [2:0] prs;
        logic [2:0] rel;
        logic [2:0] lng;
        logic [2:0] rpt;
    } exp_t;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       rst_seen = 1'b1;
    logic       done     = 1'b0;
    logic [2:0] btn      = 3'b100;
    logic [2:0] level;
    logic [2:0] press;
    logic [2:0] rel;
    logic [2:0] lng;
    logic [2:0] rpt;
    logic [2:0] exp_lvl  = 3'b000;
    int         cyc      = 0;
    int         checks   = 0;
    int         errors   = 0;
    exp_t       sb[$];
    exp_t       e;

    input_conditioner_bank #(
        .N_CH            (3),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (c_DB),
        .LONG_CYCLES     (c_LG),
        .REPEAT_CYCLES   (c_RP),
        .ACT_LOW_MASK    (3'b100)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .btn_i     (btn),
        .level_o   (level),
        .press_o   (press),
        .release_o (rel),
        .long_o    (lng),
        .repeat_o  (rpt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst;
    end

    task automatic push(input int c, input logic [2:0] l, input logic [2:0] p,
                        input logic [2:0] r, input logic [2:0] g, input logic [2:0] t);
        exp_t x;
        x.cyc = c; x.lvl = l; x.prs = p; x.rel = r; x.lng = g; x.rpt = t;
        sb.push_back(x);
    endtask

    task automatic go(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_repeats(input int long_cyc, input logic [2:0] l, input logic [2:0] ch);
`ifdef ICB_AUTOREPEAT_EN
        for (int i = 1; i <= 3; i++) push(long_cyc + i * c_RP, l, 3'b000, 3'b000, 3'b000, ch);
`else
        if (long_cyc < 0) push(0, l, 3'b000, 3'b000, 3'b000, ch);
`endif
    endtask

    // Monitor: checks reset state, pops one expectation per output event, tracks level
    always @(negedge clk) begin
        if (done) begin
            checks++;
            if (sb.size() != 0) begin
                errors++;
                $display("FAIL leftover_events got %0d pending, required 0 (next at cyc %0d)",
                         sb.size(), sb[0].cyc);
            end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end else if (rst_seen) begin
            checks++;
            exp_lvl = 3'b000;
            if ({level, press, rel, lng, rpt} != 15'd0) begin
                errors++;
                $display("FAIL reset_state cyc=%0d got lvl=%b p=%b r=%b l=%b t=%b, required all 0",
                         cyc, level, press, rel, lng, rpt);
            end
        end else if (|{press, rel, lng, rpt}) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event cyc=%0d got lvl=%b p=%b r=%b l=%b t=%b, required none",
                         cyc, level, press, rel, lng, rpt);
            end else begin
                e = sb.pop_front();
                exp_lvl = e.lvl;
                if (e.cyc != cyc || e.lvl != level || e.prs != press || e.rel != rel ||
                    e.lng != lng || e.rpt != rpt) begin
                    errors++;
                    $display("FAIL event got cyc=%0d lvl=%b p=%b r=%b l=%b t=%b, required cyc=%0d lvl=%b p=%b r=%b l=%b t=%b",
                             cyc, level, press, rel, lng, rpt,
                             e.cyc, e.lvl, e.prs, e.rel, e.lng, e.rpt);
                end
            end
        end else begin
            checks++;
            if (level != exp_lvl) begin
                errors++;
                $display("FAIL level cyc=%0d got %b, required %b", cyc, level, exp_lvl);
            end
        end
    end

    initial begin
        int k;
        // Reset with ch2 (active-low) idle-high, then 20 quiet cycles
        go(4);
        rst = 1'b0;
        go(20);

        // ch0 clean press then release before the long threshold
        btn = 3'b101; k = cyc;
        push(k + c_LAT, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000);
        go(20);
        btn = 3'b100; k = cyc;
        push(k + c_LAT, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000);
        go(15);

        // ch0 bounce: 1 for 5, 0 for 2, then steady 1
        btn = 3'b101;
        go(5);
        btn = 3'b100;
        go(2);
        btn = 3'b101; k = cyc;
        push(k + c_LAT, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000);
        go(13);
        btn = 3'b100; k = cyc;
        push(k + c_LAT, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000);
        go(15);

        // ch1 held 60 cycles: one long press, then release
        btn = 3'b110; k = cyc;
        push(k + c_LAT, 3'b010, 3'b010, 3'b000, 3'b000, 3'b000);
        push(k + c_LAT + c_LG, 3'b010, 3'b000, 3'b000, 3'b010, 3'b000);
        push_repeats(k + c_LAT + c_LG, 3'b010, 3'b010);
        go(60);
        btn = 3'b100;
        push(k + 60 + c_LAT, 3'b000, 3'b000, 3'b010, 3'b000, 3'b000);
        go(15);

        // ch0 release accepted in the very cycle the long threshold is reached
        btn = 3'b101; k = cyc;
        push(k + c_LAT, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000);
        go(c_LG);
        btn = 3'b100;
        push(k + c_LG + c_LAT, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000);
        go(15);

        // Reset mid-press: press re-reported after full latency from reset release
        btn = 3'b101; k = cyc;
        push(k + c_LAT, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000);
        go(15);
        rst = 1'b1;
        go(2);
        rst = 1'b0;
        push(k + 17 + c_LAT, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000);
        go(15);
        btn = 3'b100;
        push(k + 32 + c_LAT, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000);
        go(15);

        // All three channels (ch2 active-low) pressed and released together
        btn = 3'b011; k = cyc;
        push(k + c_LAT, 3'b111, 3'b111, 3'b000, 3'b000, 3'b000);
        go(15);
        btn = 3'b100;
        push(k + 15 + c_LAT, 3'b000, 3'b000, 3'b111, 3'b000, 3'b000);
        go(15);

        // ch0 held 60 cycles: long press plus auto-repeat when enabled
        btn = 3'b101; k = cyc;
        push(k + c_LAT, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000);
        push(k + c_LAT + c_LG, 3'b001, 3'b000, 3'b000, 3'b001, 3'b000);
        push_repeats(k + c_LAT + c_LG, 3'b001, 3'b001);
        go(60);
        btn = 3'b100;
        push(k + 60 + c_LAT, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000);
        go(30);

        done = 1'b1;
    end

endmodule

`default_nettype wire
